alu_op_executor: RTL
====================

Name: alu_op_executor

Overview:
- Consumer stage directly downstream of the 3-bit address generator.
- Holds an 8-entry instruction store (opcode plus two operands per entry), fetches the entry selected by `address`, executes it, and returns a one-cycle `op_done` pulse.
- The generator advances on that pulse (Gray order 0,1,3,2,6,7,5,4,0), so the two blocks form a closed instruction loop.
- Multiply is multi-cycle (shift-add); all other operations take one execute cycle.

Parameters:
- WIDTH, 8, operand width in bits (2..16).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- run  input  1  1 = execute continuously; 0 = stop after the current op.
- address  input  3  entry index from the address generator.
- wr_en  input  1  instruction-store write strobe.
- wr_addr  input  3  write index.
- wr_data  input  3+2*WIDTH  {opcode[2:0], opA, opB}.
- op_done  output  1  one-cycle pulse when an op completes; drives the generator's op_done.
- result  output  2*WIDTH  last completed result, held until the next completion.
- carry  output  1  carry/borrow/overflow flag of the last op.
- zero  output  1  1 when the last result == 0.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - op_done, result, carry, zero, busy = 0.
  - All 8 store entries are cleared to 0.
- Store write:
  - On a rising edge with wr_en=1, entry[wr_addr] <= wr_data.
  - Writes are allowed in any state.
  - FETCH reads the pre-edge contents (read-before-write).
- FSM states: IDLE, FETCH, EXEC, DONE.
  - IDLE: if run=1, go to FETCH next edge; otherwise stay.
  - FETCH: latch opcode, A and B from entry[address]; go to EXEC.
  - EXEC:
    - Non-MUL: compute into the result register; go to DONE.
    - MUL: one shift-add step per cycle; after exactly WIDTH cycles go to DONE.
  - DONE: op_done=1 for this single cycle. Next state is FETCH if run=1, else IDLE.
- Timing and latency:
  - The generator updates `address` on the edge ending DONE, so the following FETCH sees the new address.
  - Latency from FETCH entry to op_done: non-MUL = 2 cycles; MUL = WIDTH+1 cycles.
- Opcodes (unsigned; result is zero-extended to 2*WIDTH unless stated):
  - 000 ADD: result = A+B; carry = bit WIDTH of the sum.
  - 001 SUB: result = (A-B) mod 2^WIDTH; carry = 1 if A<B (borrow).
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 MUL: full 2*WIDTH product; carry = 1 if the upper WIDTH bits are nonzero.
  - 110 SHL1: result = {A,1'b0} in WIDTH+1 bits; carry = A[WIDTH-1].
  - 111 PASS: result = A; carry = 0.
- Output update rules:
  - result, carry and zero update only on the edge entering DONE.
  - They are stable while DONE is active and are held thereafter.
- Boundary conditions:
  - run dropping in FETCH or EXEC: the current op completes and op_done still pulses, then the FSM goes to IDLE.
  - address changing outside FETCH: ignored; operands are already latched.
  - Write to the executing entry during EXEC: no effect on the current op; it affects the next fetch of that entry.
  - Reset mid-MUL: the operation is aborted, no op_done is produced, and all outputs go to 0.
  - MUL with A=0 or B=0: still takes the full WIDTH cycles; result 0, zero=1.

Test Plan (WIDTH=8):
1. Load entry0={ADD,0xF0,0x20}; release reset; run=1 with address=0 -> op_done 2 cycles after FETCH; result=0x0110, carry=1, zero=0.
2. Closed loop with the address generator; entries i={PASS,i,0}; run=1 for 8 ops -> results 0,1,3,2,6,7,5,4 in that order, each op_done exactly 1 cycle wide.
3. Entry3={MUL,0xFF,0xFF}, address=3 -> op_done at FETCH+9; result=0xFE01, carry=1.
4. Entry1={SUB,0x05,0x07} -> result=0x00FE, carry=1; then {SUB,0x07,0x07} -> result=0, zero=1, carry=0.
5. Pull reset low 4 cycles into a MUL -> busy, op_done, result, carry and zero = 0 immediately; no op_done afterwards while run=0.
6. run deasserted during EXEC of a MUL -> op_done still pulses once, then IDLE with busy=0; a simultaneous wr_en to the executing entry does not change that result.

Source files
------------

// File: rtl/alu_op_executor.sv
// Instruction-store ALU stage: fetches {opcode, A, B} from entry[address], executes it
// (multi-cycle shift-add for MUL) and pulses op_done so the address generator can advance.
module alu_op_executor #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [2:0]             address,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [3+2*WIDTH-1:0]   wr_data,
  output logic                   op_done,
  output logic [2*WIDTH-1:0]     result,
  output logic                   carry,
  output logic                   zero,
  output logic                   busy
);

  localparam int PW = 2 * WIDTH;
  localparam int EW = 3 + PW;
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SHL1 = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [EW-1:0]       store [8];
  logic [EW-1:0]       fetch_entry;
  logic [2:0]          opc;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [PW-1:0]       acc;
  logic [PW-1:0]       acc_step;
  logic [PW-1:0]       mcand;
  logic [WIDTH-1:0]    mplier;
  logic [SW-1:0]       step;
  logic                mul_last;
  logic [PW:0]         alu_out;

  // Single-cycle operations; returns {carry, zero-extended result}. MUL is not handled here.
  function automatic logic [PW:0] alu_eval(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [PW-1:0]    res;
    logic             cy;
    sum  = {1'b0, a} + {1'b0, b};
    diff = a - b;
    res  = '0;
    cy   = 1'b0;
    case (op)
      OP_ADD:  begin res = PW'(sum);  cy = sum[WIDTH]; end
      OP_SUB:  begin res = PW'(diff); cy = (a < b);    end
      OP_AND:  res = PW'(a & b);
      OP_OR:   res = PW'(a | b);
      OP_XOR:  res = PW'(a ^ b);
      OP_SHL1: begin res = PW'({a, 1'b0}); cy = a[WIDTH-1]; end
      OP_PASS: res = PW'(a);
      default: res = '0;
    endcase
    return {cy, res};
  endfunction

  assign fetch_entry = store[address];
  assign alu_out     = alu_eval(opc, op_a, op_b);
  assign acc_step    = mplier[0] ? acc + mcand : acc;
  assign mul_last    = (step == LAST_STEP);
  assign op_done     = (state == DONE);
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    if (opc != OP_MUL || mul_last) state_nxt = DONE;
      DONE:    state_nxt = run ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction store: FETCH sees pre-edge contents because both use the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) store[i] <= '0;
    end else if (wr_en) begin
      store[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      opc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      step   <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        // FETCH: latch operands and seed the shift-add multiplier
        FETCH: begin
          opc    <= fetch_entry[EW-1 -: 3];
          op_a   <= fetch_entry[PW-1 -: WIDTH];
          op_b   <= fetch_entry[WIDTH-1:0];
          acc    <= '0;
          mcand  <= PW'(fetch_entry[PW-1 -: WIDTH]);
          mplier <= fetch_entry[WIDTH-1:0];
          step   <= '0;
        end
        // EXEC: one multiplier bit per cycle for MUL; everything else finishes now
        EXEC: begin
          if (opc == OP_MUL) begin
            acc    <= acc_step;
            mcand  <= {mcand[PW-2:0], 1'b0};
            mplier <= mplier >> 1;
            step   <= step + SW'(1);
            if (mul_last) begin
              result <= acc_step;
              carry  <= |acc_step[PW-1:WIDTH];
              zero   <= (acc_step == '0);
            end
          end else begin
            result <= alu_out[PW-1:0];
            carry  <= alu_out[PW];
            zero   <= (alu_out[PW-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
